// File: rtl/ddr5_phy_pkg.sv
// Shared constants and types for the x4 DDR5 PHY write-CRC path.
package ddr5_phy_pkg;

  localparam int BURST_BEATS = 16;
  localparam int CRC_BEATS   = 2;
  localparam int DQ_X4_W     = 4;
  localparam int CRC_W       = 8;
  localparam int BEAT_CNT_W  = $clog2(BURST_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } wr_state_e;

endpackage

// File: rtl/ddr5_phy_beat_packer.sv
// Packs x4 beat pairs into CRC generator bytes and drives the registered
// enable/data handshake, including the post-burst flush enable.
module ddr5_phy_beat_packer
  import ddr5_phy_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               beat_acc,
  input  logic               beat_odd,
  input  logic               crc_mode,
  input  logic               flush,
  input  logic [DQ_X4_W-1:0] beat_data,
  output logic               crc_en,
  output logic [CRC_W-1:0]   crc_data
);

  logic [DQ_X4_W-1:0] lo_q;
  logic               byte_rdy;

  // A byte is complete when its odd (high-nibble) beat is taken in CRC mode.
  assign byte_rdy = beat_acc & beat_odd & crc_mode;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lo_q     <= '0;
      crc_en   <= 1'b0;
      crc_data <= '0;
    end else begin
      if (beat_acc && !beat_odd) lo_q <= beat_data;
      crc_en <= flush | byte_rdy;
      if (flush)         crc_data <= '0;
      else if (byte_rdy) crc_data <= {beat_data, lo_q};
    end
  end

endmodule

// File: rtl/ddr5_phy_wr_crc_ctrl.sv
// DDR5 x4 write-CRC sequencer: 16 data beats in, 16 (+2 CRC) DQ beats out,
// with generator handshake, flush and result capture.
module ddr5_phy_wr_crc_ctrl
  import ddr5_phy_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               wr_crc_mode_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [DQ_X4_W-1:0] wr_data_i,
  output logic               crc_en_o,
  output logic [CRC_W-1:0]   crc_data_o,
  input  logic [CRC_W-1:0]   crc_code_i,
  output logic               dq_valid_o,
  output logic [DQ_X4_W-1:0] dq_data_o,
  output logic               dq_crc_o,
  output logic               crc_done_o,
  output logic [CRC_W-1:0]   crc_value_o
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BURST_BEATS - 1);

  wr_state_e              state_q, state_d;
  logic [BEAT_CNT_W-1:0]  beat_cnt_q;
  logic                   mode_q;
  logic                   tail_q;
  logic                   s1_vld_q;
  logic [DQ_X4_W-1:0]     s1_data_q;
  logic [DQ_X4_W-1:0]     crc_hi_q;

  logic accept, last_beat, beat_mode, in_wait, in_flush;

  assign wr_ready_o = (state_q == ST_IDLE) || (state_q == ST_DATA);
  assign accept     = wr_valid_i & wr_ready_o;
  assign last_beat  = accept && (beat_cnt_q == LAST_BEAT);
  assign in_wait    = (state_q == ST_WAIT);
  assign in_flush   = (state_q == ST_FLUSH);
  // Beat 0 uses the live mode bit; the rest of the burst uses the latched one.
  assign beat_mode  = (beat_cnt_q == '0) ? wr_crc_mode_i : mode_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept)    state_d = ST_DATA;
      ST_DATA:  if (last_beat) state_d = mode_q ? ST_WAIT : ST_IDLE;
      ST_WAIT:  state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      mode_q     <= 1'b0;
      tail_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      tail_q  <= in_flush;
      if (accept) beat_cnt_q <= beat_cnt_q + 1'b1;
      if (accept && beat_cnt_q == '0) mode_q <= wr_crc_mode_i;
    end
  end

  ddr5_phy_beat_packer u_packer (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .beat_acc  (accept),
    .beat_odd  (beat_cnt_q[0]),
    .crc_mode  (beat_mode),
    .flush     (in_wait),
    .beat_data (wr_data_i),
    .crc_en    (crc_en_o),
    .crc_data  (crc_data_o)
  );

  // Stage 1: accepted beat.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) s1_data_q <= wr_data_i;
    end
  end

  // Stage 2: DQ output. Stage 1 is always empty during FLUSH and the tail
  // cycle because ready is low for the two cycles after beat 15.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dq_valid_o  <= 1'b0;
      dq_data_o   <= '0;
      dq_crc_o    <= 1'b0;
      crc_done_o  <= 1'b0;
      crc_value_o <= '0;
      crc_hi_q    <= '0;
    end else begin
      crc_done_o <= in_flush;
      if (in_flush) begin
        crc_value_o <= crc_code_i;
        crc_hi_q    <= crc_code_i[CRC_W-1:DQ_X4_W];
        dq_valid_o  <= 1'b1;
        dq_data_o   <= crc_code_i[DQ_X4_W-1:0];
        dq_crc_o    <= 1'b1;
      end else if (tail_q) begin
        dq_valid_o <= 1'b1;
        dq_data_o  <= crc_hi_q;
        dq_crc_o   <= 1'b1;
      end else begin
        dq_valid_o <= s1_vld_q;
        dq_data_o  <= s1_data_q;
        dq_crc_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddr5_phy_wr_crc_ctrl.sv
// Bench for ddr5_phy_wr_crc_ctrl: scenario table, reset sequence and random
// bursts, all checked cycle by cycle against a schedule-based reference model.
module tb_ddr5_phy_wr_crc_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b1;
  logic       wr_crc_mode_i = 1'b0;
  logic       wr_valid_i = 1'b0;
  logic [3:0] wr_data_i = 4'h0;
  logic       wr_ready_o, crc_en_o, dq_valid_o, dq_crc_o, crc_done_o;
  logic [7:0] crc_data_o, crc_code_i, crc_value_o;
  logic [3:0] dq_data_o;

  always #5 clk_i = ~clk_i;

  ddr5_phy_wr_crc_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .wr_crc_mode_i(wr_crc_mode_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .crc_en_o(crc_en_o), .crc_data_o(crc_data_o), .crc_code_i(crc_code_i),
    .dq_valid_o(dq_valid_o), .dq_data_o(dq_data_o), .dq_crc_o(dq_crc_o),
    .crc_done_o(crc_done_o), .crc_value_o(crc_value_o)
  );

  // CRC-8, polynomial x^8+x^2+x+1, MSB first, zero init.
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  function automatic logic [7:0] ramp_crc();
    logic [7:0] a;
    a = 8'h00;
    for (int k = 0; k < 8; k++) a = crc8(a, {4'(2*k+1), 4'(2*k)});
    return a;
  endfunction

  // Generator stand-in: result state after 8 enables, 9th enable flushes.
  bit         use_stub = 1'b0;
  int         gen_cnt;
  logic [7:0] gen_acc;
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gen_cnt <= 0;
      gen_acc <= 8'h00;
    end else if (crc_en_o) begin
      if (gen_cnt == 8) begin
        gen_cnt <= 0;
        gen_acc <= 8'h00;
      end else begin
        gen_cnt <= gen_cnt + 1;
        gen_acc <= crc8(gen_acc, crc_data_o);
      end
    end
  end
  assign crc_code_i = (gen_cnt == 8) ? (use_stub ? 8'hA5 : gen_acc) : 8'h00;

  // Reference model: expected events keyed by cycle number.
  typedef struct { logic [3:0] d; logic c; } dq_exp_t;
  dq_exp_t    exp_dq   [int];
  logic [7:0] exp_en   [int];
  logic [7:0] exp_done [int];
  bit         rdy_low  [int];

  int         cyc, n_vec, n_err;
  int         beat_m;
  logic       mode_m;
  logic [3:0] prev_m;
  logic [7:0] macc, exp_val;
  bit         last_acc;
  int         en_cnt, dqcrc_cnt, rdylo_cnt, done_cnt, run, max_run;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_dq.delete(); exp_en.delete(); exp_done.delete(); rdy_low.delete();
    beat_m = 0; mode_m = 1'b0; prev_m = 4'h0; macc = 8'h00; exp_val = 8'h00;
  endtask

  task automatic model_cycle();
    bit         rdy_exp;
    logic [7:0] crc;
    rdy_exp = !rdy_low.exists(cyc);
    chk("wr_ready", wr_ready_o, rdy_exp);
    if (!wr_ready_o) rdylo_cnt++;
    if (exp_dq.exists(cyc)) begin
      chk("dq_valid", dq_valid_o, 1);
      chk("dq_data", dq_data_o, exp_dq[cyc].d);
      chk("dq_crc", dq_crc_o, exp_dq[cyc].c);
    end else begin
      chk("dq_valid", dq_valid_o, 0);
      chk("dq_crc", dq_crc_o, 0);
    end
    if (dq_valid_o === 1'b1) begin run++; if (run > max_run) max_run = run; end
    else run = 0;
    if (dq_crc_o === 1'b1) dqcrc_cnt++;
    if (exp_en.exists(cyc)) begin
      chk("crc_en", crc_en_o, 1);
      chk("crc_data", crc_data_o, exp_en[cyc]);
    end else chk("crc_en", crc_en_o, 0);
    if (crc_en_o === 1'b1) en_cnt++;
    if (exp_done.exists(cyc)) begin
      exp_val = exp_done[cyc];
      chk("crc_done", crc_done_o, 1);
    end else chk("crc_done", crc_done_o, 0);
    if (crc_done_o === 1'b1) done_cnt++;
    chk("crc_value", crc_value_o, exp_val);

    // Acceptance at the coming edge and its consequences.
    last_acc = wr_valid_i && rdy_exp;
    if (last_acc) begin
      if (beat_m == 0) begin mode_m = wr_crc_mode_i; macc = 8'h00; end
      exp_dq[cyc+2] = '{d: wr_data_i, c: 1'b0};
      if (mode_m && beat_m % 2 == 1) begin
        exp_en[cyc+1] = {wr_data_i, prev_m};
        macc = crc8(macc, {wr_data_i, prev_m});
      end
      prev_m = wr_data_i;
      if (beat_m == 15) begin
        beat_m = 0;
        if (mode_m) begin
          crc = use_stub ? 8'hA5 : macc;
          rdy_low[cyc+1] = 1'b1;
          rdy_low[cyc+2] = 1'b1;
          exp_en[cyc+2]  = 8'h00;
          exp_dq[cyc+3]  = '{d: crc[3:0], c: 1'b1};
          exp_dq[cyc+4]  = '{d: crc[7:4], c: 1'b1};
          exp_done[cyc+3] = crc;
        end
      end else beat_m++;
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    model_cycle();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    wr_valid_i = 1'b0;
    wr_data_i  = 4'($urandom_range(0, 15));
    repeat (n) step();
  endtask

  task automatic drive_beat(input logic [3:0] d, input logic m);
    int guard;
    guard = 0;
    wr_valid_i = 1'b1; wr_data_i = d; wr_crc_mode_i = m;
    do begin step(); guard++; end while (!last_acc && guard < 16);
    if (!last_acc) chk("accept_timeout", 0, 1);
  endtask

  // pat: 0 ramp, 1 zeros, 2 random. Mode bit is randomised after beat 0.
  task automatic burst(input logic mode, input int pat, input int nbeats,
                       input int ga, input int gb, input int gl, input bit rgap);
    logic [3:0] d;
    for (int b = 0; b < nbeats; b++) begin
      d = (pat == 0) ? 4'(b) : (pat == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      drive_beat(d, (b == 0) ? mode : 1'($urandom_range(0, 1)));
      if (b == ga || b == gb) idle(gl);
      if (rgap && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_wr_ready", wr_ready_o, 1);
    chk("rst_crc_en", crc_en_o, 0);
    chk("rst_crc_data", crc_data_o, 8'h00);
    chk("rst_dq_valid", dq_valid_o, 0);
    chk("rst_dq_data", dq_data_o, 4'h0);
    chk("rst_dq_crc", dq_crc_o, 0);
    chk("rst_crc_done", crc_done_o, 0);
    chk("rst_crc_value", crc_value_o, 8'h00);
  endtask

  task automatic clear_stats();
    en_cnt = 0; dqcrc_cnt = 0; rdylo_cnt = 0; done_cnt = 0; run = 0; max_run = 0;
  endtask

  typedef struct {
    logic       mode;
    bit         stub;
    int         pat;
    int         nb;
    int         ga, gb, gl;
    int         exp_en, exp_run, exp_rdylo;
    bit         chk_crc;
    logic [7:0] exp_crc;
  } vec_t;

  vec_t tv [6];

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    model_clear();
    clear_stats();

    tv[0] = '{1'b1, 1'b1, 0, 1, -1, -1, 0,  9, 18, 2, 1'b1, 8'hA5};
    tv[1] = '{1'b1, 1'b0, 1, 1, -1, -1, 0,  9, 18, 2, 1'b1, 8'h00};
    tv[2] = '{1'b1, 1'b1, 0, 2, -1, -1, 0, 18, 36, 4, 1'b1, 8'hA5};
    tv[3] = '{1'b0, 1'b0, 0, 2, -1, -1, 0,  0, 32, 0, 1'b0, 8'h00};
    tv[4] = '{1'b1, 1'b0, 0, 1,  4, 11, 3,  9, -1, 2, 1'b1, ramp_crc()};
    tv[5] = '{1'b1, 1'b0, 0, 1, -1, -1, 0,  9, 18, 2, 1'b1, ramp_crc()};

    #2 rst_n_i = 1'b0;
    #1 check_reset_vals();
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    idle(2);

    for (int i = 0; i < 6; i++) begin
      use_stub = tv[i].stub;
      clear_stats();
      for (int n = 0; n < tv[i].nb; n++)
        burst(tv[i].mode, tv[i].pat, 16, tv[i].ga, tv[i].gb, tv[i].gl, 1'b0);
      idle(8);
      chk("en_count", en_cnt, tv[i].exp_en);
      chk("dq_crc_count", dqcrc_cnt, 2 * tv[i].nb * int'(tv[i].mode));
      chk("done_count", done_cnt, tv[i].nb * int'(tv[i].mode));
      chk("ready_low_cycles", rdylo_cnt, tv[i].exp_rdylo);
      if (tv[i].exp_run >= 0) chk("dq_run", max_run, tv[i].exp_run);
      if (tv[i].chk_crc) chk("crc_value_end", crc_value_o, tv[i].exp_crc);
    end

    // Reset after beat 9 of a CRC burst, then a clean burst.
    use_stub = 1'b0;
    burst(1'b1, 0, 10, -1, -1, 0, 1'b0);
    rst_n_i = 1'b0;
    wr_valid_i = 1'b0;
    #1 check_reset_vals();
    model_clear();
    idle(2);
    rst_n_i = 1'b1;
    clear_stats();
    burst(1'b1, 0, 16, -1, -1, 0, 1'b0);
    idle(8);
    chk("post_rst_crc", crc_value_o, ramp_crc());
    chk("post_rst_en_count", en_cnt, 9);
    chk("post_rst_done", done_cnt, 1);

    // Random bursts: random data, mode, gaps and back-to-back spacing.
    for (int n = 0; n < 24; n++) begin
      burst(1'($urandom_range(0, 1)), 2, 16, -1, -1, 0, 1'b1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

endmodule

// File: doc/ddr5_phy_wr_crc_ctrl.md
# ddr5_phy_wr_crc_ctrl

Write-path sequencer for the x4 DDR5 PHY write CRC. It accepts 16-beat x4 write bursts from the write data block and packs beat pairs into bytes. It drives the 8-bit CRC generator's enable/data handshake, flushes and captures the generator result, and emits an 18-beat DQ stream: 16 data beats followed by 2 CRC beats. With CRC disabled, bursts pass through as 16 beats with the generator idle.

## Interface
- Parameters: none; x4 width, BL16 and 8-bit CRC are fixed.
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset; one clock, shared with the CRC generator
- wr_crc_mode_i  in  1  write-CRC enable (mode register); sampled on beat-0 acceptance
- wr_valid_i  in  1  write beat valid
- wr_ready_o  out  1  beat accepted when wr_valid_i & wr_ready_o
- wr_data_i  in  4  write beat data
- crc_en_o  out  1  generator enable, registered
- crc_data_o  out  8  generator data byte, registered
- crc_code_i  in  8  generator result; non-zero only in its result state
- dq_valid_o  out  1  DQ beat valid
- dq_data_o  out  4  DQ beat data
- dq_crc_o  out  1  current DQ beat is a CRC beat
- crc_done_o  out  1  one-cycle pulse, CRC captured
- crc_value_o  out  8  last captured CRC, held until the next capture

## Operation
- Burst boundaries come only from an internal 4-bit beat counter (0..15). Gaps in wr_valid_i are legal mid-burst; dq_valid_o is low for the corresponding cycles.
- Byte k = {beat 2k+1, beat 2k}; beat 2k occupies bits [3:0].
- CRC mode:
  - The low nibble of each even beat is held.
  - On acceptance of odd beat 2k+1, crc_en_o=1 and crc_data_o=byte k are set for the next cycle.
  - Result: exactly 8 data enables per burst.
- Generator contract:
  - After 8 enables, the generator is in its result state.
  - One further enable (FLUSH) returns it to idle; crc_code_i is valid during that cycle.
- FSM states:
  - IDLE: ready=1, waiting for beat 0. Beat 0 accepted → DATA; wr_crc_mode_i is latched.
  - DATA: ready=1. Beat 15 accepted → WAIT if CRC mode, else IDLE.
  - WAIT: ready=0; byte 7 enable is on crc_en_o. → FLUSH.
  - FLUSH: ready=0; crc_en_o=1, crc_data_o=0x00; crc_code_i captured into crc_value_o and the hi-nibble register; dq_data_o loads crc[3:0]. → IDLE with tail flag set.
  - Tail cycle (first IDLE cycle): dq_data_o loads crc[7:4]. Beat 0 of the next burst may be accepted in this cycle.
- Non-CRC mode: no crc_en_o pulses; no ready gap between bursts.
- wr_crc_mode_i changes mid-burst are ignored until the next beat 0.

## Timing
- Data latency: a beat accepted in cycle t appears on dq_data_o in cycle t+2 (two register stages).
- CRC burst with beat 15 accepted at t:
  - t+1 (WAIT): crc_en_o=1 for byte 7.
  - t+2 (FLUSH): crc_en_o=1; dq shows beat 15.
  - t+3: dq shows crc[3:0] with dq_crc_o=1; crc_done_o=1.
  - t+4: dq shows crc[7:4] with dq_crc_o=1.
- wr_ready_o is low for exactly t+1 and t+2. The earliest next beat 0 is accepted at t+3 and appears at t+5, so back-to-back bursts are DQ-contiguous.
- Reset values: wr_ready_o=1, crc_en_o=0, crc_data_o=0x00, dq_valid_o=0, dq_data_o=0, dq_crc_o=0, crc_done_o=0, crc_value_o=0x00; FSM=IDLE; counter=0; tail=0.
- Reset mid-burst: all state cleared; the generator is reset by the same rst_n_i, so no flush is owed.
- Beat counter wraps 15→0 on beat-15 acceptance in both modes.

## Structure
- Shared package ddr5_phy_pkg holds:
  - the state enum (IDLE/DATA/WAIT/FLUSH)
  - BURST_BEATS=16, CRC_BEATS=2, DQ_X4_W=4, CRC_W=8
- One natural sub-module: ddr5_phy_beat_packer (even-nibble hold plus byte/enable register).
- The FSM, DQ pipeline and CRC capture stay in the top module.

## Test plan
- CRC mode, beats 0x0..0xF, generator stub returns 0xA5 in its result state:
  - crc_data_o sequence 0x10,0x32,0x54,0x76,0x98,0xBA,0xDC,0xFE, then 0x00 (flush) = 9 enables.
  - DQ shows 18 beats; beat16=0x5, beat17=0xA; crc_value_o=0xA5.
- CRC mode with the real CRC-8 generator, all-zero burst:
  - beats 16/17 = 0x0; crc_done_o pulses once at t+3.
- Two back-to-back CRC bursts, wr_valid_i held high:
  - wr_ready_o low for exactly 2 cycles.
  - dq_valid_o continuous for 36 cycles.
- CRC disabled, two back-to-back bursts:
  - crc_en_o never asserted; 32 contiguous DQ beats; dq_crc_o=0 throughout.
- Burst with 3-cycle gaps after beats 4 and 11:
  - still exactly 8 data enables plus 1 flush.
  - dq_valid_o shows the same gaps; CRC unchanged vs. the no-gap run.
- rst_n_i asserted after beat 9:
  - all outputs at reset values immediately (asynchronous).
  - the next full burst produces the correct CRC.
